// File: rtl/run_arbiter_if.sv
// Request/grant/completion bundle between requesters and the shared run arbiter.
// Latency: none, plain wires.
// Backpressure: none; requests are levels, done/run are single-cycle pulses.
interface run_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] i_req;
  logic               i_engine_done;
  logic               o_run;
  logic [NUM_REQ-1:0] o_grant;
  logic [IDW-1:0]     o_grant_id;
  logic [NUM_REQ-1:0] o_done;
  logic               o_timeout;
  logic               o_busy;

  // Requester side: drives requests and the engine completion pulse.
  modport master (
    output i_req, i_engine_done,
    input  o_run, o_grant, o_grant_id, o_done, o_timeout, o_busy
  );

  // Arbiter side.
  modport slave (
    input  i_req, i_engine_done,
    output o_run, o_grant, o_grant_id, o_done, o_timeout, o_busy
  );
endinterface

// File: rtl/run_arbiter.sv
// Round-robin owner arbitration for one shared run engine, with done timeout.
// Latency: request in IDLE -> grant+run next cycle; engine done -> o_done next cycle.
// Backpressure: requests are held off while busy; one service at a time, no queueing.
module run_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic         i_clock,
  input  logic         i_reset_sync_n,
  run_arbiter_if.slave bus
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [7:0]     CNT_LIMIT = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [IDW-1:0] LAST_RST  = IDW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] owner_q, owner_d;
  logic [IDW-1:0] last_q,  last_d;
  logic [7:0]     cnt_q,   cnt_d;
  logic           tout_q,  tout_d;

  logic           win_found;
  logic [IDW-1:0] win_id;
  logic [IDW-1:0] idx;

  // State register; reset abandons any service in flight without notifying anyone.
  always_ff @(posedge i_clock) begin
    if (!i_reset_sync_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Owner, rotation pointer, wait counter and timeout flag.
  always_ff @(posedge i_clock) begin
    if (!i_reset_sync_n) begin
      owner_q <= '0;
      last_q  <= LAST_RST;
      cnt_q   <= '0;
      tout_q  <= 1'b0;
    end else begin
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      tout_q  <= tout_d;
    end
  end

  // Round-robin pick: first active request strictly after the last served id, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    idx       = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = IDW'((int'(last_q) + i) % NUM_REQ);
      if (!win_found && bus.i_req[idx]) begin
        win_found = 1'b1;
        win_id    = idx;
      end
    end
  end

  // Next-state and datapath update; engine done is only looked at while waiting.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    tout_d  = tout_q;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          owner_d = win_id;
          state_d = ST_START;
        end
      end
      ST_START: begin
        cnt_d   = '0;
        tout_d  = 1'b0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        // A done arriving on the limit cycle still counts as a normal completion.
        if (bus.i_engine_done) begin
          tout_d  = 1'b0;
          state_d = ST_DONE;
        end else if (cnt_q == CNT_LIMIT) begin
          tout_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        last_d  = owner_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded purely from registered state, so no input reaches an output.
  always_comb begin
    bus.o_busy     = (state_q != ST_IDLE);
    bus.o_run      = (state_q == ST_START);
    bus.o_grant    = '0;
    bus.o_grant_id = '0;
    bus.o_done     = '0;
    bus.o_timeout  = 1'b0;
    if (state_q != ST_IDLE) begin
      bus.o_grant    = NUM_REQ'(1) << owner_q;
      bus.o_grant_id = owner_q;
    end
    if (state_q == ST_DONE) begin
      bus.o_done    = NUM_REQ'(1) << owner_q;
      bus.o_timeout = tout_q;
    end
  end
endmodule

// File: tb/tb_run_arbiter.sv
// Self-checking bench for run_arbiter: directed vector table, corner sequences, random vs model.
// Latency: checks outputs 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_run_arbiter;
  localparam int N = 4;
  localparam int T = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  run_arbiter_if #(.NUM_REQ(N)) bus ();

  run_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(T)) dut (
    .i_clock        (clk),
    .i_reset_sync_n (rst_n),
    .bus            (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Transaction-level reference: who owns the engine, when it started, when it ends.
  int m_owner = -1;
  int m_start = 0;
  int m_end   = -1;
  int m_last  = N - 1;
  bit m_tflag = 1'b0;

  typedef struct {
    logic       rn;
    logic [3:0] req;
    logic       done;
    logic [3:0] grant;
    logic [1:0] id;
    logic       run;
    logic [3:0] dn;
    logic       to;
    logic       busy;
  } vec_t;

  vec_t vt[15];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_step(input logic [N-1:0] req, input logic done, input logic rn);
    int prev;
    prev = cyc - 1;
    if (!rn) begin
      m_owner = -1;
      m_last  = N - 1;
      m_end   = -1;
      m_tflag = 1'b0;
    end else if (m_owner < 0) begin
      for (int i = 1; i <= N; i++) begin
        int k;
        k = (m_last + i) % N;
        if (req[k]) begin
          m_owner = k;
          m_start = cyc;
          m_end   = -1;
          m_tflag = 1'b0;
          break;
        end
      end
    end else if (m_end >= 0 && prev == m_end) begin
      m_last  = m_owner;
      m_owner = -1;
      m_end   = -1;
    end else if (m_end < 0 && prev > m_start) begin
      if (done) begin
        m_end   = cyc;
        m_tflag = 1'b0;
      end else if (cyc - m_start == T + 1) begin
        m_end   = cyc;
        m_tflag = 1'b1;
      end
    end
  endtask

  task automatic model_check();
    int e_grant, e_id, e_run, e_done, e_to, e_busy;
    e_busy  = (m_owner >= 0) ? 1 : 0;
    e_grant = e_busy ? (1 << m_owner) : 0;
    e_id    = e_busy ? m_owner : 0;
    e_run   = (e_busy && cyc == m_start) ? 1 : 0;
    e_done  = (e_busy && cyc == m_end) ? e_grant : 0;
    e_to    = (e_busy && cyc == m_end && m_tflag) ? 1 : 0;
    check("model_grant",    int'(bus.o_grant),    e_grant);
    check("model_grant_id", int'(bus.o_grant_id), e_id);
    check("model_run",      int'(bus.o_run),      e_run);
    check("model_done",     int'(bus.o_done),     e_done);
    check("model_timeout",  int'(bus.o_timeout),  e_to);
    check("model_busy",     int'(bus.o_busy),     e_busy);
  endtask

  // One clock: drive inputs, advance the model at the edge, compare just after it.
  task automatic tick(input logic rn, input logic [N-1:0] req, input logic done);
    rst_n             = rn;
    bus.i_req         = req;
    bus.i_engine_done = done;
    @(posedge clk);
    cyc++;
    model_step(req, done, rn);
    #1;
    model_check();
  endtask

  function automatic vec_t mk(input logic rn, input logic [3:0] req, input logic done,
                              input logic [3:0] grant, input logic [1:0] id, input logic run,
                              input logic [3:0] dn, input logic to, input logic busy);
    vec_t v;
    v.rn = rn; v.req = req; v.done = done; v.grant = grant; v.id = id;
    v.run = run; v.dn = dn; v.to = to; v.busy = busy;
    return v;
  endfunction

  initial begin
    int exp_ids[5];
    int k;
    logic [N-1:0] rreq;

    bus.i_req         = '0;
    bus.i_engine_done = 1'b0;

    // Requester 2 alone, done three cycles after run, then ignored-done and reset-in-WAIT cases.
    vt[0]  = mk(1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0, 1'b0);
    vt[1]  = mk(1'b1, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 4'b0000, 1'b0, 1'b1);
    vt[2]  = mk(1'b1, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b0, 4'b0000, 1'b0, 1'b1);
    vt[3]  = mk(1'b1, 4'b0000, 1'b0, 4'b0100, 2'd2, 1'b0, 4'b0000, 1'b0, 1'b1);
    vt[4]  = mk(1'b1, 4'b0000, 1'b0, 4'b0100, 2'd2, 1'b0, 4'b0000, 1'b0, 1'b1);
    vt[5]  = mk(1'b1, 4'b0000, 1'b1, 4'b0100, 2'd2, 1'b0, 4'b0100, 1'b0, 1'b1);
    vt[6]  = mk(1'b1, 4'b0100, 1'b1, 4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0, 1'b0);
    vt[7]  = mk(1'b1, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 4'b0000, 1'b0, 1'b1);
    vt[8]  = mk(1'b1, 4'b0100, 1'b1, 4'b0100, 2'd2, 1'b0, 4'b0000, 1'b0, 1'b1);
    vt[9]  = mk(1'b1, 4'b0010, 1'b0, 4'b0100, 2'd2, 1'b0, 4'b0000, 1'b0, 1'b1);
    vt[10] = mk(1'b0, 4'b0010, 1'b0, 4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0, 1'b0);
    vt[11] = mk(1'b1, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 4'b0000, 1'b0, 1'b1);
    vt[12] = mk(1'b1, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b0, 4'b0000, 1'b0, 1'b1);
    vt[13] = mk(1'b1, 4'b0010, 1'b1, 4'b0010, 2'd1, 1'b0, 4'b0010, 1'b0, 1'b1);
    vt[14] = mk(1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0, 1'b0);

    for (int i = 0; i < 15; i++) begin
      tick(vt[i].rn, vt[i].req, vt[i].done);
      check($sformatf("vec%0d_grant", i),    int'(bus.o_grant),    int'(vt[i].grant));
      check($sformatf("vec%0d_grant_id", i), int'(bus.o_grant_id), int'(vt[i].id));
      check($sformatf("vec%0d_run", i),      int'(bus.o_run),      int'(vt[i].run));
      check($sformatf("vec%0d_done", i),     int'(bus.o_done),     int'(vt[i].dn));
      check($sformatf("vec%0d_timeout", i),  int'(bus.o_timeout),  int'(vt[i].to));
      check($sformatf("vec%0d_busy", i),     int'(bus.o_busy),     int'(vt[i].busy));
    end

    // No requests after reset: everything stays quiet.
    tick(1'b0, 4'b0000, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 4'b0000, 1'b0);
      check("idle_outputs", int'({bus.o_run, bus.o_busy, bus.o_timeout, bus.o_grant,
                                  bus.o_done, bus.o_grant_id}), 0);
    end

    // All four requesting, done one cycle after each run: strict rotation from 0.
    exp_ids = '{0, 1, 2, 3, 0};
    tick(1'b0, 4'b0000, 1'b0);
    for (int s = 0; s < 5; s++) begin
      k = 0;
      do begin
        tick(1'b1, 4'b1111, 1'b0);
        k++;
      end while (!bus.o_run && k < 10);
      check("rot_run_seen", int'(bus.o_run), 1);
      check("rot_grant_id", int'(bus.o_grant_id), exp_ids[s]);
      tick(1'b1, 4'b1111, 1'b0);
      tick(1'b1, 4'b1111, 1'b1);
      check("rot_done", int'(bus.o_done), 1 << exp_ids[s]);
      check("rot_timeout", int'(bus.o_timeout), 0);
    end

    // No done at all: timeout completion exactly T+1 cycles after run.
    tick(1'b0, 4'b0000, 1'b0);
    tick(1'b1, 4'b0001, 1'b0);
    check("to_run", int'(bus.o_run), 1);
    k = 0;
    do begin
      tick(1'b1, 4'b0001, 1'b0);
      k++;
    end while (bus.o_done == '0 && k < 20);
    check("to_delay", k, T + 1);
    check("to_done", int'(bus.o_done), 1);
    check("to_flag", int'(bus.o_timeout), 1);

    // Done on the very cycle the counter reaches its limit: normal completion wins.
    tick(1'b0, 4'b0000, 1'b0);
    tick(1'b1, 4'b0001, 1'b0);
    check("lim_run", int'(bus.o_run), 1);
    for (int i = 0; i < T; i++) tick(1'b1, 4'b0001, 1'b0);
    check("lim_not_yet", int'(bus.o_done), 0);
    tick(1'b1, 4'b0001, 1'b1);
    check("lim_done", int'(bus.o_done), 1);
    check("lim_flag", int'(bus.o_timeout), 0);

    // Random traffic, sticky requests, sparse done pulses and rare resets.
    rreq = '0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) rreq = N'($urandom_range(0, 15));
      tick(($urandom_range(0, 199) != 0), rreq, ($urandom_range(0, 5) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
